// File: rtl/ring_arbiter.sv
// Four-requester round-robin arbiter. It grants one requester at a time and
// releases on done, on the owner dropping its request, or after MAX_HOLD cycles.
module ring_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic       timeout,
  output logic [3:0] ptr
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [5:0] HOLD_LIMIT = 6'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic [1:0] id_q, id_d;
  logic       timeout_q, timeout_d;
  logic [3:0] ptr_q, ptr_d;
  logic [5:0] hold_q, hold_d;

  logic [1:0] ptr_idx;
  logic [1:0] sel_idx;
  logic       sel_found;
  logic       owner_req;
  logic       at_limit;
  logic       release_now;

  // Search starts at the pointer position; the 2-bit index sum wraps 3 -> 0.
  always_comb begin
    ptr_idx   = 2'd0;
    sel_idx   = 2'd0;
    sel_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ptr_q[i]) ptr_idx = 2'(i);
    end
    for (int k = 0; k < 4; k++) begin
      if (!sel_found && req[ptr_idx + 2'(k)]) begin
        sel_found = 1'b1;
        sel_idx   = ptr_idx + 2'(k);
      end
    end
  end

  assign owner_req   = req[id_q];
  assign at_limit    = (hold_q == HOLD_LIMIT);
  assign release_now = done || !owner_req || at_limit;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d   = state_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && sel_found) begin
          state_d = BUSY;
          gnt_d   = 4'b0001 << sel_idx;
          valid_d = 1'b1;
          id_d    = sel_idx;
          hold_d  = 6'd1;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          valid_d   = 1'b0;
          id_d      = 2'd0;
          hold_d    = 6'd0;
          ptr_d     = {gnt_q[2:0], gnt_q[3]};
          // A simultaneous done or request drop counts as a normal release.
          timeout_d = at_limit && !done && owner_req;
        end else begin
          hold_d = hold_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      valid_q   <= 1'b0;
      id_q      <= 2'd0;
      timeout_q <= 1'b0;
      ptr_q     <= 4'b0001;
      hold_q    <= 6'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;
  assign timeout   = timeout_q;
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_ring_arbiter.sv
// Directed bench for ring_arbiter: reset, rotation order, wrap-around search,
// forced release at MAX_HOLD, reset during a grant, and the enable gate.
module tb_ring_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;
  logic [3:0] ptr;

  int total = 0;
  int bad   = 0;

  ring_arbiter #(.MAX_HOLD(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .timeout  (timeout),
    .ptr      (ptr)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed observation: {gnt, gnt_valid, gnt_id, timeout, ptr}.
  function automatic logic [11:0] obs();
    return {gnt, gnt_valid, gnt_id, timeout, ptr};
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    req    = 4'b0000;
    done   = 1'b0;
    step();
    step();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs() !== {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001}) begin
      bad++;
      $display("FAIL reset_state: got %b expected %b", obs(), {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001});
    end
  endtask

  task automatic test_single_grant();
    do_reset();
    enable = 1'b1;
    req    = 4'b0001;
    step();
    total++;
    if (obs() !== {4'b0001, 1'b1, 2'd0, 1'b0, 4'b0001}) begin
      bad++;
      $display("FAIL single_grant: got %b expected %b", obs(), {4'b0001, 1'b1, 2'd0, 1'b0, 4'b0001});
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    total++;
    if (obs() !== {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010}) begin
      bad++;
      $display("FAIL single_release: got %b expected %b", obs(), {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010});
    end
    // done in IDLE must be ignored
    done = 1'b1;
    step();
    done = 1'b0;
    total++;
    if (obs() !== {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010}) begin
      bad++;
      $display("FAIL done_in_idle: got %b expected %b", obs(), {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] ids   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    enable = 1'b1;
    req    = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      total++;
      if (gnt !== order[n] || gnt_id !== ids[n] || gnt_valid !== 1'b1) begin
        bad++;
        $display("FAIL rr_grant%0d: got gnt=%b id=%0d v=%b expected gnt=%b id=%0d v=1",
                 n, gnt, gnt_id, gnt_valid, order[n], ids[n]);
      end
      step();
      total++;
      if (gnt !== order[n]) begin
        bad++;
        $display("FAIL rr_hold%0d: got gnt=%b expected %b", n, gnt, order[n]);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      total++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0 ||
          ptr !== {order[n][2:0], order[n][3]}) begin
        bad++;
        $display("FAIL rr_gap%0d: got gnt=%b v=%b to=%b ptr=%b expected gnt=0000 v=0 to=0 ptr=%b",
                 n, gnt, gnt_valid, timeout, ptr, {order[n][2:0], order[n][3]});
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    enable = 1'b1;
    req    = 4'b0010;
    step();
    done = 1'b1;
    req  = 4'b0000;
    step();
    done = 1'b0;
    total++;
    if (ptr !== 4'b0100) begin
      bad++;
      $display("FAIL wrap_setup_ptr: got %b expected 0100", ptr);
    end
    req = 4'b0011;
    step();
    total++;
    if (obs() !== {4'b0001, 1'b1, 2'd0, 1'b0, 4'b0100}) begin
      bad++;
      $display("FAIL wrap_grant: got %b expected %b", obs(), {4'b0001, 1'b1, 2'd0, 1'b0, 4'b0100});
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    total++;
    if (obs() !== {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010}) begin
      bad++;
      $display("FAIL wrap_release: got %b expected %b", obs(), {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    enable = 1'b1;
    req    = 4'b0010;
    // Forced release: granted for exactly 16 cycles.
    for (int c = 1; c <= 16; c++) begin
      step();
      total++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1 || timeout !== 1'b0) begin
        bad++;
        $display("FAIL to_hold_cycle%0d: got gnt=%b id=%0d to=%b expected gnt=0010 id=1 to=0",
                 c, gnt, gnt_id, timeout);
      end
    end
    step();
    total++;
    if (obs() !== {4'b0000, 1'b0, 2'd0, 1'b1, 4'b0100}) begin
      bad++;
      $display("FAIL to_release: got %b expected %b", obs(), {4'b0000, 1'b0, 2'd0, 1'b1, 4'b0100});
    end
    // Request still held: regranted after the one-cycle gap, timeout pulse gone.
    step();
    total++;
    if (obs() !== {4'b0010, 1'b1, 2'd1, 1'b0, 4'b0100}) begin
      bad++;
      $display("FAIL to_regrant: got %b expected %b", obs(), {4'b0010, 1'b1, 2'd1, 1'b0, 4'b0100});
    end
    for (int c = 2; c <= 16; c++) step();
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL to_cycle16_second: got gnt=%b expected 0010", gnt);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    total++;
    if (obs() !== {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100}) begin
      bad++;
      $display("FAIL to_done_at_limit: got %b expected %b", obs(), {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100});
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    enable = 1'b1;
    req    = 4'b0100;
    step();
    total++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      bad++;
      $display("FAIL mid_grant_setup: got gnt=%b id=%0d expected gnt=0100 id=2", gnt, gnt_id);
    end
    step();
    reset = 1'b1;
    step();
    total++;
    if (obs() !== {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001}) begin
      bad++;
      $display("FAIL mid_grant_reset: got %b expected %b", obs(), {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001});
    end
    reset = 1'b0;
    req   = 4'b0000;
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b1;
    req    = 4'b0100;
    step();
    done = 1'b1;
    req  = 4'b0000;
    step();
    done   = 1'b0;
    enable = 1'b0;
    req    = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step();
      total++;
      if (gnt !== 4'b0000 || ptr !== 4'b1000) begin
        bad++;
        $display("FAIL en_low_cycle%0d: got gnt=%b ptr=%b expected gnt=0000 ptr=1000", c, gnt, ptr);
      end
    end
    enable = 1'b1;
    step();
    total++;
    if (obs() !== {4'b1000, 1'b1, 2'd3, 1'b0, 4'b1000}) begin
      bad++;
      $display("FAIL en_grant: got %b expected %b", obs(), {4'b1000, 1'b1, 2'd3, 1'b0, 4'b1000});
    end
    // Disabling during a grant does not end it; dropping the owner's request does.
    enable = 1'b0;
    step();
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("FAIL en_low_busy: got gnt=%b expected 1000", gnt);
    end
    req = 4'b0111;
    step();
    total++;
    if (obs() !== {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001}) begin
      bad++;
      $display("FAIL req_drop_release: got %b expected %b", obs(), {4'b0000, 1'b0, 2'd0, 1'b0, 4'b0001});
    end
    req = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid_grant();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
